// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART shared constants and state encodings
// Contents: register addresses, reset divisor, oversample factor, TX/RX FSM states.
package spart_pkg;

    localparam logic [1:0]  ADDR_DATA     = 2'b00;
    localparam logic [1:0]  ADDR_STATUS   = 2'b01;
    localparam logic [1:0]  ADDR_DIV_LO   = 2'b10;
    localparam logic [1:0]  ADDR_DIV_HI   = 2'b11;

    localparam logic [15:0] RESET_DIVISOR = 16'd162;
    localparam int          OVERSAMPLE    = 16;

    // Tick-counter values: last tick of a bit, and the mid-bit tick of the start bit.
    localparam logic [3:0]  TICK_LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  TICK_MID      = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// rtl/spart_baud_gen.sv - SPART 16-bit baud tick generator
// Ports: clk, rst (async active-low), divisor (value used for load/reload),
//        load (reload counter now), tick (one-cycle pulse, period divisor+1).
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        load,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RESET_DIVISOR;
        end else if (load || cnt == 16'd0) begin
            cnt <= divisor;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart.sv
// rtl/spart.sv - SPART: bus-programmable 8N1 UART with 16x oversampling
// Ports: clk, rst (async active-low), iocs/iorw/ioaddr bus control, databus (inout),
//        rda (rx data available), tbr (tx buffer ready), txd (serial out), rxd (serial in).
// Option macro SPART_ERR_STATUS_EN: adds overrun (bit 2) and framing error (bit 3) status.
module spart
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        wr_tx, wr_lo, wr_hi, rd_rx, rd_status;
    logic [15:0] divisor, div_next;
    logic        tick;
    logic [7:0]  status, rd_data;

    assign wr_tx     = iocs && !iorw && (ioaddr == ADDR_DATA);
    assign wr_lo     = iocs && !iorw && (ioaddr == ADDR_DIV_LO);
    assign wr_hi     = iocs && !iorw && (ioaddr == ADDR_DIV_HI);
    assign rd_rx     = iocs &&  iorw && (ioaddr == ADDR_DATA);
    assign rd_status = iocs &&  iorw && (ioaddr == ADDR_STATUS);

    // ---------------- divisor and baud generator ----------------
    // The counter reloads from the merged new value in the same cycle the byte lands.
    always_comb begin
        div_next = divisor;
        if (wr_lo) div_next[7:0]  = databus;
        if (wr_hi) div_next[15:8] = databus;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) divisor <= RESET_DIVISOR;
        else      divisor <= div_next;
    end

    spart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (div_next),
        .load    (wr_lo || wr_hi),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state;
    logic [3:0] tx_ticks;
    logic [2:0] tx_bit;
    logic [7:0] tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_ticks <= 4'd0;
            tx_bit   <= 3'd0;
            tx_data  <= 8'd0;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            if (wr_tx && tbr) begin
                tx_data <= databus;
                tbr     <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    // A pending byte (tbr low) starts on the next tick.
                    if (!tbr && tick) begin
                        tx_state <= TX_START;
                        tx_ticks <= 4'd0;
                        txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_ticks == TICK_LAST) begin
                            tx_state <= TX_DATA;
                            tx_ticks <= 4'd0;
                            tx_bit   <= 3'd0;
                            txd      <= tx_data[0];
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_ticks == TICK_LAST) begin
                            tx_ticks <= 4'd0;
                            if (tx_bit == 3'd7) begin
                                tx_state <= TX_STOP;
                                txd      <= 1'b1;
                            end else begin
                                tx_bit <= tx_bit + 3'd1;
                                txd    <= tx_data[tx_bit + 3'd1];
                            end
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_ticks == TICK_LAST) begin
                            tx_state <= TX_IDLE;
                            tx_ticks <= 4'd0;
                            tbr      <= 1'b1;
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_t  rx_state;
    logic [3:0] rx_ticks;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift, rx_buf;
    logic       rx_s1, rx_s2, rx_prev;
    logic       rx_done, rx_load;

    // rx_done marks the mid-stop-bit sample; rx_s2 is the stop value.
    assign rx_done = (rx_state == RX_STOP) && tick && (rx_ticks == TICK_LAST);
`ifdef SPART_ERR_STATUS_EN
    assign rx_load = rx_done;
`else
    assign rx_load = rx_done && rx_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_ticks <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_buf   <= 8'hFF;
            rda      <= 1'b0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_ticks <= 4'd0;
                    end
                end
                RX_START: begin
                    // Mid-start check; from here every 16 ticks is a mid-bit point.
                    if (tick) begin
                        if (rx_ticks == TICK_MID) begin
                            rx_ticks <= 4'd0;
                            rx_bit   <= 3'd0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_ticks == TICK_LAST) begin
                            rx_ticks <= 4'd0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            if (rx_bit == 3'd7) rx_state <= RX_STOP;
                            else                rx_bit   <= rx_bit + 3'd1;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_ticks == TICK_LAST) begin
                            rx_state <= RX_IDLE;
                            rx_ticks <= 4'd0;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
            // A completing byte wins over a simultaneous data read.
            if (rx_load) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
            end else if (rd_rx) begin
                rda <= 1'b0;
            end
        end
    end

`ifdef SPART_ERR_STATUS_EN
    logic rx_ovr, rx_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovr  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            if (rx_load && rda) rx_ovr <= 1'b1;
            else if (rd_status) rx_ovr <= 1'b0;
            if (rx_done && !rx_s2) rx_ferr <= 1'b1;
            else if (rd_status)    rx_ferr <= 1'b0;
        end
    end

    assign status = {4'b0, rx_ferr, rx_ovr, tbr, rda};
`else
    assign status = {6'b0, tbr, rda};
`endif

    // ---------------- bus read path ----------------
    assign rd_data = (ioaddr == ADDR_DATA) ? rx_buf : status;
    assign databus = (rst && (rd_rx || rd_status)) ? rd_data : 8'hzz;

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all state updates on posedge clk.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port iocs, input, 1 bit: chip select; bus access occurs only when iocs=1.
REQ-004 The block SHALL have the port iorw, input, 1 bit: 1 = read, 0 = write.
REQ-005 The block SHALL have the port ioaddr, input, 2 bits: register select.
REQ-006 The block SHALL have the port databus, inout, 8 bits: bidirectional data; SPART drives it only during reads.
REQ-007 The block SHALL have the port rda, output, 1 bit: receive data available.
REQ-008 The block SHALL have the port tbr, output, 1 bit: transmit buffer ready.
REQ-009 The block SHALL have the port txd, output, 1 bit: serial out; idle high.
REQ-010 The block SHALL have the port rxd, input, 1 bit: serial in; asynchronous to clk.

Function
REQ-011 The register map SHALL be: addr 00 read = RX buffer; addr 00 write = TX buffer; addr 01 read = status {6'b0, tbr, rda}; addr 10 write = divisor low; addr 11 write = divisor high.
REQ-012 Reads of 10/11 and writes to 01 SHALL be ignored; databus SHALL be Z on them.
REQ-013 databus SHALL be driven combinationally iff iocs=1, iorw=1 and ioaddr is 00 or 01; otherwise Z.
REQ-014 The baud generator SHALL be a 16-bit down-counter that emits a one-cycle tick on reaching 0, then reloads the divisor; tick period = divisor+1 clocks.
REQ-015 Each serial bit SHALL last 16 ticks (16x oversampling); divisor 325/162/81/40 SHALL give 4800/9600/19200/38400 baud at 25 MHz.
REQ-016 Any divisor-byte write SHALL update that byte next cycle and reload the counter from the new 16-bit value.
REQ-017 The TX frame SHALL be 8N1: start 0, data LSB first, stop 1.
REQ-018 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 A TX write with tbr=1 SHALL latch the data, drop tbr the next cycle, and begin START at the next tick.
REQ-020 A TX write with tbr=0 SHALL be ignored.
REQ-021 tbr SHALL rise in the cycle after the stop bit's 16th tick.
REQ-022 rxd SHALL pass through a two-flop synchronizer before any use.
REQ-023 The RX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-024 In RX IDLE, a synchronized falling edge SHALL enter START.
REQ-025 At START tick 8, if rxd=1 the RX FSM SHALL treat it as a false start and return to IDLE; otherwise it SHALL sample each data bit every 16 ticks thereafter, at the mid-bit point.
REQ-026 If the stop bit samples 1, the byte SHALL load into the RX buffer and rda SHALL be set the next cycle.
REQ-027 rda SHALL clear in the cycle after a read of addr 00.
REQ-028 If a byte completes in the same cycle as an addr 00 read, the new byte SHALL be loaded and rda SHALL remain 1.
REQ-029 A byte completing while rda=1 SHALL overwrite the RX buffer.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 While rst=0, the block SHALL hold: txd=1, tbr=1, rda=0, RX buffer=8'hFF, divisor=16'd162, baud counter=162, both FSMs IDLE, synchronizer flops=1, databus Z.
REQ-032 Reset asserted mid-frame SHALL abort both frames immediately with no partial RX load.

Configuration
REQ-033 The block SHALL support the macro SPART_ERR_STATUS_EN.
REQ-034 With SPART_ERR_STATUS_EN defined, status bit 2 SHALL be overrun (set by REQ-029, cleared by a status read) and status bit 3 SHALL be framing error (set on stop=0, cleared by a status read); a bad-stop byte SHALL still load and set rda.
REQ-035 With SPART_ERR_STATUS_EN undefined, status bits [7:2] SHALL read 0 and frames with stop=0 SHALL be discarded without setting rda.

Structure
REQ-036 Package spart_pkg SHALL hold: the address constants, the reset divisor 16'd162, the oversample factor 16, and the TX/RX state encodings.
REQ-037 The baud generator SHALL be the sub-module spart_baud_gen (clk, rst, divisor in, load strobe, tick out).
REQ-038 The TX path, RX path and bus decode SHALL reside in spart.

Verification
REQ-039 Reset, then read addr 01 -> databus=8'h02; txd=1; writes to addr 01 leave status unchanged.
REQ-040 Write divisor 40 (lo 8'h28, hi 8'h00), then write TX 8'hA5 -> txd shows 0,1,0,1,0,0,1,0,1,1 at 656 clocks per bit; tbr=0 throughout and =1 after the stop bit.
REQ-041 Loop txd to rxd and send 8'h3C -> rda=1 after the frame; read addr 00 -> 8'h3C; rda=0 the next cycle.
REQ-042 Apply a 4-tick low glitch on rxd -> false start, no rda, RX FSM back to IDLE.
REQ-043 Send two bytes with no read between them -> RX buffer holds the second byte; with SPART_ERR_STATUS_EN defined, status = 8'h07 (plus tbr).
REQ-044 Assert rst mid-TX-frame -> txd=1 and tbr=1 immediately; the next write transmits normally.
